// File: rtl/dmg_vram_pkg.sv
// Shared types and widths for the VRAM bus arbiter slice.
package dmg_vram_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {OWN_PPU, OWN_DMA, OWN_CPU} owner_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_e;

  // Meaning of the round-robin last_grant bit: who was served most recently.
  localparam logic LG_DMA = 1'b0;
  localparam logic LG_CPU = 1'b1;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational grant picker: PPU always first, then DMA/CPU by fixed or
// round-robin policy (round-robin when VRAM_ARB_RR_EN is defined).
module vram_arb_pick
  import dmg_vram_pkg::*;
(
  input  logic       ppu_req_i,
  input  logic       dma_req_i,
  input  logic       cpu_req_i,
  input  logic       ppu_lock_i,
  input  logic       last_grant_i,
  output logic [2:0] grant_o,
  output logic       blocked_o
);

`ifndef VRAM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant_o   = '0;
    blocked_o = 1'b0;
    if (ppu_req_i) begin
      grant_o[OWN_PPU] = 1'b1;
    end else if (dma_req_i && cpu_req_i && !ppu_lock_i) begin
`ifdef VRAM_ARB_RR_EN
      if (last_grant_i == LG_CPU) grant_o[OWN_DMA] = 1'b1;
      else                        grant_o[OWN_CPU] = 1'b1;
`else
      grant_o[OWN_DMA] = 1'b1;
`endif
    end else if (dma_req_i) begin
      grant_o[OWN_DMA] = 1'b1;
    end else if (cpu_req_i) begin
      // A locked-out CPU never competes; it only completes when nobody else waits.
      if (ppu_lock_i) blocked_o = 1'b1;
      else            grant_o[OWN_CPU] = 1'b1;
    end
  end

endmodule

// File: rtl/vram_bus_arbiter.sv
// VRAM bus arbiter: PPU/DMA/CPU share one external bus, fixed-length accesses,
// CPU lockout in mode 3. Define VRAM_ARB_RR_EN for DMA/CPU round-robin.
module vram_bus_arbiter
  import dmg_vram_pkg::*;
#(
  parameter int unsigned        ACCESS_CYC = 2,
  parameter logic [DATA_W-1:0]  LOCK_RDATA = 8'hff
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              ppu_lock,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_done,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ma,
  output logic [DATA_W-1:0] md_out,
  input  logic [DATA_W-1:0] md_in,
  output logic              md_oe,
  output logic              moe,
  output logic              mwr,
  output logic              mcs
);

  localparam logic [2:0] CNT_LOAD = 3'(ACCESS_CYC - 1);

  state_e              state_q, state_d;
  owner_e              own_q, own_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                blk_q, blk_d;
  logic [2:0]          grant;
  logic                blocked;
  logic                arb_en;
  logic                last_grant;

  assign arb_en = (state_q != ST_ACC);

  vram_arb_pick u_pick (
    .ppu_req_i    (ppu_req),
    .dma_req_i    (dma_req),
    .cpu_req_i    (cpu_req),
    .ppu_lock_i   (ppu_lock),
    .last_grant_i (last_grant),
    .grant_o      (grant),
    .blocked_o    (blocked)
  );

`ifdef VRAM_ARB_RR_EN
  logic lg_q, lg_d;

  always_comb begin
    lg_d = lg_q;
    if (arb_en) begin
      if (grant[OWN_DMA])                 lg_d = LG_DMA;
      else if (grant[OWN_CPU] || blocked) lg_d = LG_CPU;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) lg_q <= LG_CPU;
    else       lg_q <= lg_d;
  end

  assign last_grant = lg_q;
`else
  assign last_grant = LG_CPU;
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    blk_d   = 1'b0;
    case (state_q)
      ST_ACC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = md_in;
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE arbitrate identically, so back-to-back accesses skip IDLE.
        state_d = ST_IDLE;
        if (|grant) begin
          state_d = ST_ACC;
          cnt_d   = CNT_LOAD;
          if (grant[OWN_PPU]) begin
            own_d  = OWN_PPU;
            addr_d = ppu_addr;
            we_d   = 1'b0;
          end else if (grant[OWN_DMA]) begin
            own_d  = OWN_DMA;
            addr_d = dma_addr;
            we_d   = 1'b0;
          end else begin
            own_d   = OWN_CPU;
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
          end
        end else if (blocked) begin
          blk_d = 1'b1;
          if (!cpu_we) rdata_d = LOCK_RDATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_PPU;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      blk_q   <= blk_d;
    end
  end

  assign mcs      = (state_q == ST_ACC);
  assign moe      = mcs && !we_q;
  assign md_oe    = mcs && we_q;
  assign md_out   = md_oe ? wdata_q : '0;
  assign mwr      = md_oe && (cnt_q == '0);
  assign ma       = addr_q;
  assign rdata    = rdata_q;
  assign ppu_done = (state_q == ST_DONE) && (own_q == OWN_PPU);
  assign dma_done = (state_q == ST_DONE) && (own_q == OWN_DMA);
  assign cpu_done = ((state_q == ST_DONE) && (own_q == OWN_CPU)) || blk_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Scoreboard bench for vram_bus_arbiter: per-requester expected-result queues
// filled at issue time and drained on done pulses; second instance at ACCESS_CYC=1.
module tb_vram_bus_arbiter;
  import dmg_vram_pkg::*;

  typedef struct packed {
    logic       chk;
    logic [7:0] data;
  } exp_t;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic        ppu_lock = 1'b0;
  logic        ppu_req = 1'b0, dma_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] ppu_addr = '0, dma_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        ppu_done, dma_done, cpu_done;
  logic [7:0]  rdata, md_out, md_in;
  logic [12:0] ma;
  logic        md_oe, moe, mwr, mcs;

  logic        ppu_req1 = 1'b0;
  logic        ppu_done1, dma_done1, cpu_done1;
  logic [7:0]  rdata1, md_out1;
  logic [12:0] ma1;
  logic        md_oe1, moe1, mwr1, mcs1;

  logic [7:0]  vmem [0:8191];
  exp_t        exp_ppu[$], exp_dma[$], exp_cpu[$];
  int          order_q[$], time_q[$];
  int          n_done[3];
  int          n_tests = 0, n_fail = 0, cyc = 0, mcs_cnt = 0, mwr_cnt = 0;

  assign md_in = vmem[ma];

  always #5 clk1 = ~clk1;

  vram_bus_arbiter u_dut (
    .clk1(clk1), .reset(reset), .ppu_lock(ppu_lock),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_done(ppu_done),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_done(dma_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .rdata(rdata),
    .ma(ma), .md_out(md_out), .md_in(md_in), .md_oe(md_oe),
    .moe(moe), .mwr(mwr), .mcs(mcs)
  );

  vram_bus_arbiter #(.ACCESS_CYC(1)) u_dut1 (
    .clk1(clk1), .reset(reset), .ppu_lock(1'b0),
    .ppu_req(ppu_req1), .ppu_addr(13'h0042), .ppu_done(ppu_done1),
    .dma_req(1'b0), .dma_addr(13'h0000), .dma_done(dma_done1),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(13'h0000),
    .cpu_wdata(8'h00), .cpu_done(cpu_done1), .rdata(rdata1),
    .ma(ma1), .md_out(md_out1), .md_in(8'h00), .md_oe(md_oe1),
    .moe(moe1), .mwr(mwr1), .mcs(mcs1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int who, input logic we, input logic [12:0] a, input logic [7:0] d);
    exp_t e;
    e.chk  = !we;
    e.data = (who == 2 && ppu_lock) ? 8'hff : vmem[a];
    case (who)
      0: begin ppu_addr = a; ppu_req = 1'b1; exp_ppu.push_back(e); end
      1: begin dma_addr = a; dma_req = 1'b1; exp_dma.push_back(e); end
      default: begin
        cpu_addr = a; cpu_we = we; cpu_wdata = d; cpu_req = 1'b1;
        exp_cpu.push_back(e);
      end
    endcase
  endtask

  task automatic sb_pop(input int who, input string nm);
    exp_t e;
    logic ok;
    ok = 1'b0;
    e  = '0;
    case (who)
      0: if (exp_ppu.size() > 0) begin e = exp_ppu.pop_front(); ok = 1'b1; end
      1: if (exp_dma.size() > 0) begin e = exp_dma.pop_front(); ok = 1'b1; end
      default: if (exp_cpu.size() > 0) begin e = exp_cpu.pop_front(); ok = 1'b1; end
    endcase
    check({nm, "_done_expected"}, 32'(ok), 32'd1);
    if (ok && e.chk) check({nm, "_rdata"}, 32'(rdata), 32'(e.data));
    n_done[who]++;
    order_q.push_back(who);
    time_q.push_back(cyc);
  endtask

  task automatic wait_done(input int who, input int target, input string tag);
    int k;
    k = 0;
    while (n_done[who] < target && k < 60) begin
      @(negedge clk1); #1;
      k++;
    end
    check({tag, "_in_time"}, 32'(n_done[who] >= target), 32'd1);
  endtask

  // Monitor: VRAM write model, bus statistics, scoreboard drain, req release.
  initial forever begin
    @(negedge clk1);
    cyc++;
    if (mcs) mcs_cnt++;
    if (mwr) begin
      mwr_cnt++;
      vmem[ma] = md_out;
    end
    if (ppu_done) begin sb_pop(0, "ppu"); ppu_req = 1'b0; end
    if (dma_done) begin sb_pop(1, "dma"); dma_req = 1'b0; end
    if (cpu_done) begin sb_pop(2, "cpu"); cpu_req = 1'b0; end
  end

  initial begin
    int base, c0, m0, w0, nd1;
    int exp_ord[4];
    logic [7:0] pre;
`ifdef VRAM_ARB_RR_EN
    exp_ord = '{0, 1, 2, 1};
`else
    exp_ord = '{0, 1, 1, 2};
`endif
    for (int i = 0; i < 8192; i++) vmem[i] = 8'(i * 7 + 3);
    vmem[13'h1234] = 8'h5a;
    n_done = '{0, 0, 0};

    repeat (3) @(negedge clk1);
    check("reset_bus", 32'({ma, md_out, md_oe, moe, mwr, mcs}), 32'd0);
    check("reset_done_rdata", 32'({ppu_done, dma_done, cpu_done, rdata}), 32'd0);
    #1 reset = 1'b0;

    // CPU read of 0x1234
    @(negedge clk1); #1;
    issue(2, 1'b0, 13'h1234, 8'h00);
    @(negedge clk1);
    check("rd_acc1", 32'({ma, moe, mcs, md_oe, mwr, cpu_done}), 32'({13'h1234, 5'b11000}));
    @(negedge clk1);
    check("rd_acc2", 32'({ma, moe, mcs, md_oe, mwr, cpu_done}), 32'({13'h1234, 5'b11000}));
    @(negedge clk1);
    check("rd_done", 32'({cpu_done, mcs, moe}), 32'b100);

    // CPU write 0x0010 = 0xC3
    @(negedge clk1); #1;
    issue(2, 1'b1, 13'h0010, 8'hc3);
    @(negedge clk1);
    check("wr_acc1", 32'({md_out, md_oe, mcs, moe, mwr}), 32'({8'hc3, 4'b1100}));
    @(negedge clk1);
    check("wr_acc2", 32'({md_out, md_oe, mcs, moe, mwr}), 32'({8'hc3, 4'b1101}));
    @(negedge clk1);
    check("wr_done", 32'({cpu_done, mcs, md_oe, mwr}), 32'b1000);
    check("wr_mem", 32'(vmem[13'h0010]), 32'h0000_00c3);

    // All three requesters at once, DMA re-requests after its first service
    @(negedge clk1); #1;
    order_q.delete();
    time_q.delete();
    base = n_done[1];
    c0   = n_done[2];
    issue(0, 1'b0, 13'h0100, 8'h00);
    issue(1, 1'b0, 13'h0200, 8'h00);
    issue(2, 1'b0, 13'h0300, 8'h00);
    wait_done(1, base + 1, "prio_dma1");
    issue(1, 1'b0, 13'h0201, 8'h00);
    wait_done(2, c0 + 1, "prio_cpu");
    wait_done(1, base + 2, "prio_dma2");
    check("prio_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < order_q.size()) check($sformatf("prio_order%0d", i), 32'(order_q[i]), 32'(exp_ord[i]));
      if (i > 0 && i < time_q.size()) check($sformatf("prio_gap%0d", i), 32'(time_q[i] - time_q[i-1]), 32'd3);
    end

    // Locked-out CPU read and write
    @(negedge clk1); #1;
    ppu_lock = 1'b1;
    m0 = mcs_cnt;
    w0 = mwr_cnt;
    issue(2, 1'b0, 13'h0000, 8'h00);
    @(negedge clk1);
    check("blk_rd_done", 32'(cpu_done), 32'd1);
    repeat (2) @(negedge clk1);
    check("blk_rd_no_mcs", 32'(mcs_cnt), 32'(m0));
    #1;
    pre = vmem[13'h0005];
    issue(2, 1'b1, 13'h0005, 8'h77);
    @(negedge clk1);
    check("blk_wr_done", 32'(cpu_done), 32'd1);
    repeat (2) @(negedge clk1);
    check("blk_wr_no_mwr", 32'(mwr_cnt), 32'(w0));
    check("blk_wr_no_mcs", 32'(mcs_cnt), 32'(m0));
    check("blk_wr_mem", 32'(vmem[13'h0005]), 32'(pre));
    #1 ppu_lock = 1'b0;

    // Reset during the first ACC cycle of a DMA read
    @(negedge clk1); #1;
    issue(1, 1'b0, 13'h0400, 8'h00);
    @(negedge clk1);
    check("abort_in_acc", 32'({mcs, moe}), 32'b11);
    #1 reset = 1'b1;
    @(negedge clk1);
    check("abort_bus", 32'({ma, md_out, md_oe, moe, mwr, mcs}), 32'd0);
    check("abort_done_rdata", 32'({ppu_done, dma_done, cpu_done, rdata}), 32'd0);
    #1;
    exp_dma.delete();
    dma_req = 1'b0;
    reset   = 1'b0;
    base    = n_done[1];
    repeat (3) @(negedge clk1);
    check("abort_no_done", 32'(n_done[1]), 32'(base));
    #1;
    issue(1, 1'b0, 13'h0401, 8'h00);
    wait_done(1, base + 1, "abort_fresh");

    // ACCESS_CYC=1 instance with a continuous PPU request
    @(negedge clk1); #1;
    ppu_req1 = 1'b1;
    for (int k = 0; k < 10 && !ppu_done1; k++) @(negedge clk1);
    check("c1_first_done", 32'(ppu_done1), 32'd1);
    nd1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk1);
      if (ppu_done1) nd1++;
      check($sformatf("c1_alt%0d", k), 32'(ppu_done1 ^ mcs1), 32'd1);
    end
    check("c1_done_count", 32'(nd1), 32'd5);
    #1 ppu_req1 = 1'b0;

    repeat (3) @(negedge clk1);
    check("sb_empty", 32'(exp_ppu.size() + exp_dma.size() + exp_cpu.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
